// File: rtl/sam_phase_search_pkg.sv
// Shared constants and state encoding for the sample-phase acquisition path.
package sam_phase_search_pkg;
  localparam int SPS      = 4;
  localparam int LOG2_SPS = 2;
  localparam int SAMPLE_W = 18;
  localparam int MAG_W    = SAMPLE_W - 1;

  typedef enum logic [2:0] {IDLE, ALIGN, ACCUM, CMP, UPD} state_t;
endpackage

// File: rtl/sam_abs_sat.sv
// Signed 1s17 sample to 17-bit unsigned magnitude; the most negative code saturates.
module sam_abs_sat
  import sam_phase_search_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [MAG_W-1:0]    mag
);
  logic [SAMPLE_W-1:0] neg;

  always_comb begin
    neg = -sample;
    if (sample == {1'b1, {MAG_W{1'b0}}}) begin
      mag = {MAG_W{1'b1}};
    end else if (sample[SAMPLE_W-1]) begin
      mag = neg[MAG_W-1:0];
    end else begin
      mag = sample[MAG_W-1:0];
    end
  end
endmodule

// File: rtl/sam_phase_search.sv
// Sample-phase search: accumulates |in| per phase over a symbol window and
// picks the delay-line tap that moves the strongest phase onto the strobe.
module sam_phase_search
  import sam_phase_search_pkg::*;
#(
  parameter int LOG2_SYMS = 8,
  parameter int ACC_W     = 17 + LOG2_SYMS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sam_clk_en,
  input  logic                sym_clk_en,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] in,
  output logic [1:0]          delay,
  output logic                busy,
  output logic                done
);
  localparam int CNT_W = LOG2_SYMS + 1;
  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(1 << LOG2_SYMS);

  state_t              state;
  logic [LOG2_SPS-1:0] phase;
  logic [LOG2_SPS-1:0] cur_phase;
  logic [LOG2_SPS-1:0] cmp_idx;
  logic [LOG2_SPS-1:0] best_idx;
  logic [LOG2_SPS-1:0] final_idx;
  logic [CNT_W-1:0]    sym_cnt;
  logic [ACC_W-1:0]    acc [SPS];
  logic [ACC_W-1:0]    best;
  logic [MAG_W-1:0]    mag;
  logic                acc_clr;
  logic                acc_add;
  logic                last_sample;

  sam_abs_sat u_abs (
    .sample (in),
    .mag    (mag)
  );

  // Phase of the sample currently on the input; `phase` holds the previous one.
  assign cur_phase   = sym_clk_en ? '0 : phase + 1'b1;
  assign acc_clr     = (state == IDLE) && start;
  assign acc_add     = sam_clk_en && (((state == ALIGN) && sym_clk_en) || (state == ACCUM));
  assign last_sample = acc_add && (state == ACCUM) && (cur_phase == 2'd3) && (sym_cnt == LAST_SYM);
  assign final_idx   = (acc[cmp_idx] > best) ? cmp_idx : best_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (sam_clk_en) begin
      phase <= cur_phase;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SPS; i++) acc[i] <= '0;
    end else if (acc_clr) begin
      for (int i = 0; i < SPS; i++) acc[i] <= '0;
    end else if (acc_add) begin
      acc[cur_phase] <= acc[cur_phase] + ACC_W'(mag);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      delay    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sym_cnt  <= '0;
      cmp_idx  <= '0;
      best     <= '0;
      best_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ALIGN;
            busy    <= 1'b1;
            sym_cnt <= '0;
          end
        end
        ALIGN: begin
          if (sam_clk_en && sym_clk_en) begin
            state   <= ACCUM;
            sym_cnt <= sym_cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (sam_clk_en && sym_clk_en) sym_cnt <= sym_cnt + 1'b1;
          if (last_sample) begin
            state   <= CMP;
            cmp_idx <= '0;
          end
        end
        CMP: begin
          cmp_idx <= cmp_idx + 1'b1;
          if ((cmp_idx == 2'd0) || (acc[cmp_idx] > best)) begin
            best     <= acc[cmp_idx];
            best_idx <= cmp_idx;
          end
          // Final compare folds straight into the tap so done and delay land together.
          if (cmp_idx == 2'd3) begin
            state <= UPD;
            delay <= 2'd0 - final_idx;
            done  <= 1'b1;
          end
        end
        UPD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sam_phase_search.sv
// Directed bench for sam_phase_search with a per-cycle reference model.
module tb_sam_phase_search;
  localparam int L    = 2;
  localparam int NSYM = 1 << L;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sam_clk_en = 1'b0;
  logic        sym_clk_en = 1'b0;
  logic        start = 1'b0;
  logic [17:0] din = '0;
  logic [1:0]  delay;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  bit mon = 1'b0;

  always #5 clk = ~clk;

  sam_phase_search #(.LOG2_SYMS(L)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .start      (start),
    .in         (din),
    .delay      (delay),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: spec rules evaluated per clock edge with plain arithmetic.
  int cyc = 0;
  bit m_idle = 1'b1, m_aligned = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int m_count = 0, m_due = -1, m_phase = 0, m_delay = 0, m_pending = 0;
  int m_sum [4];
  int last_sum [4];

  always @(posedge clk) begin
    int v, ph, best, bp;
    cyc++;
    if (!reset_n) begin
      m_idle = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_delay = 0;
      m_due = -1; m_phase = 0; m_aligned = 1'b0;
    end else begin
      ph = sym_clk_en ? 0 : (m_phase + 1) % 4;
      if (m_idle) begin
        if (start) begin
          m_idle = 1'b0; m_busy = 1'b1; m_aligned = 1'b0; m_count = 0;
          m_sum = '{default: 0};
        end
      end else if (m_due >= 0) begin
        if (cyc == m_due) begin
          m_done = 1'b1; m_delay = m_pending;
        end else if (cyc == m_due + 1) begin
          m_done = 1'b0; m_busy = 1'b0; m_idle = 1'b1; m_due = -1;
        end
      end else if (sam_clk_en) begin
        if (sym_clk_en) m_aligned = 1'b1;
        if (m_aligned) begin
          v = $signed(din);
          v = (v < 0) ? -v : v;
          if (v > 131071) v = 131071;
          m_sum[ph] += v;
          m_count++;
          if (m_count == 4 * NSYM) begin
            best = -1; bp = 0;
            for (int p = 0; p < 4; p++) if (m_sum[p] > best) begin best = m_sum[p]; bp = p; end
            m_pending = (4 - bp) % 4;
            m_due = cyc + 4;  // done occupies the 5th cycle after the last sample's cycle
            last_sum = m_sum;
          end
        end
      end
      if (sam_clk_en) m_phase = ph;
    end
  end

  always @(negedge clk) begin
    if (reset_n && mon) begin
      check("done", int'(done), int'(m_done));
      check("busy", int'(busy), int'(m_busy));
      check("delay", int'(delay), m_delay);
    end
    if (reset_n && done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit strobe, input int gap);
    sam_clk_en = 1'b1; sym_clk_en = strobe; din = v[17:0];
    tick();
    sam_clk_en = 1'b0; sym_clk_en = 1'b0; din = '0;
    repeat (gap) tick();
  endtask

  task automatic stream(input int nsym, input int v0, input int v1, input int v2, input int v3,
                        input bit alt, input int maxgap);
    int vals [4];
    int val, gap;
    vals = '{v0, v1, v2, v3};
    for (int s = 0; s < nsym; s++) begin
      for (int p = 0; p < 4; p++) begin
        val = (alt && (s % 2 == 1)) ? -vals[p] : vals[p];
        gap = (maxgap > 0 && !(s == nsym - 1 && p == 3)) ? int'($urandom_range(maxgap, 0)) : 0;
        send(val, p == 0, gap);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called right after the last sample's edge; returns cycles from that sample to done.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_search(input string name, input int d0, input int exp_delay);
    int lat;
    wait_done(lat);
    check({name, "_latency"}, lat, 5);
    check({name, "_delay"}, int'(delay), exp_delay);
    repeat (3) tick();
    check({name, "_dones"}, n_done - d0, 1);
    check({name, "_idle"}, int'(busy), 0);
    $display("search %s delay=%0d latency=%0d", name, delay, lat);
  endtask

  task automatic do_search(input string name, input int v0, input int v1, input int v2, input int v3,
                           input bit alt, input int maxgap, input int exp_delay);
    int d0;
    d0 = n_done;
    pulse_start();
    stream(NSYM, v0, v1, v2, v3, alt, maxgap);
    finish_search(name, d0, exp_delay);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_delay", int'(delay), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset_n = 1'b1;
    mon = 1'b1;
    repeat (2) tick();

    do_search("peak_p2", 0, 0, 1000, 0, 1'b0, 0, 2);
    check("peak_p2_sum", last_sum[2], 4000);
    do_search("peak_p1", 0, 1000, 0, 0, 1'b0, 0, 3);

    // Abort mid-accumulation while delay holds 3.
    check("pre_reset_delay", int'(delay), 3);
    pulse_start();
    stream(2, 0, 0, 5000, 0, 1'b0, 0);
    reset_n = 1'b0;
    #1;
    check("abort_delay", int'(delay), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    tick(); tick();
    reset_n = 1'b1;
    d0 = n_done;
    repeat (30) tick();
    check("abort_no_done", n_done - d0, 0);
    check("abort_idle", int'(busy), 0);
    $display("search abort delay=%0d", delay);

    do_search("sat_p3", 0, 0, 0, -131072, 1'b0, 0, 1);
    check("sat_sum3", last_sum[3], 524284);
    do_search("mixed_p0", 500, 0, 400, 0, 1'b1, 0, 0);
    do_search("tie_p1_p3", 0, 700, 0, -700, 1'b0, 0, 3);

    // Start between strobes, large pre-strobe samples must be skipped; extra start ignored.
    d0 = n_done;
    pulse_start();
    send(100000, 1'b0, 1);
    send(-90000, 1'b0, 0);
    stream(2, 0, 0, 1000, 0, 1'b0, 0);
    pulse_start();
    stream(2, 0, 0, 1000, 0, 1'b0, 0);
    finish_search("late_start", d0, 2);

    do_search("irregular_p3", 0, 200, 0, 1000, 1'b0, 6, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
